// File: rtl/asynchronous_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : asynchronous_fifo                                            |
// | Description : Single-clock show-ahead (first-word-fall-through) FIFO built |
// |               on a circular buffer with ADDR_WIDTH+1 bit pointers. The     |
// |               extra pointer MSB tells a full buffer from an empty one.     |
// |               Reset is asynchronous, active-high, and clears all state.    |
// | Ports       : clock    - single clock, rising edge                         |
// |               reset    - asynchronous active-high reset                    |
// |               w_en     - write request (dropped when full)                 |
// |               r_en     - pop request (ignored when empty)                  |
// |               data_in  - write data                                        |
// |               data_out - head-of-FIFO word, valid while empty=0            |
// |               full     - DEPTH entries stored                              |
// |               empty    - no entries stored                                 |
// | Option      : define ASYNC_FIFO_STATUS_EN to add the outputs               |
// |               level     - current occupancy (wptr - rptr)                  |
// |               overflow  - sticky, write attempted while full               |
// |               underflow - sticky, read attempted while empty               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module asynchronous_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef ASYNC_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic write_ok;
  logic read_ok;

  // Flags come straight from the registered pointers, so both reflect the
  // pre-edge state when deciding whether a request is accepted.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                    (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign write_ok = w_en && !full;
  assign read_ok  = r_en && !empty;

  // Show-ahead: the head word is presented without a read register.
  assign data_out = mem[rptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      // Storage is cleared so data_out never shows X, even while empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (write_ok) begin
        mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        wptr                      <= wptr + PTR_ONE;
      end
      if (read_ok) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

`ifdef ASYNC_FIFO_STATUS_EN
  // Modular subtraction yields occupancy 0..DEPTH across pointer laps.
  assign level = wptr - rptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_asynchronous_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_asynchronous_fifo                                         |
// | Description : Directed self-checking bench for asynchronous_fifo with      |
// |               hand-computed expectations and a small queue model for the   |
// |               streaming section.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_asynchronous_fifo;

  logic       clock;
  logic       reset;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ASYNC_FIFO_STATUS_EN
  logic [3:0] level;
  logic       overflow;
  logic       underflow;
`endif

  int tests_run;
  int tests_failed;

  logic [7:0] model_q[$];

  asynchronous_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .w_en    (w_en),
    .r_en    (r_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
`ifdef ASYNC_FIFO_STATUS_EN
    ,
    .level    (level),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock cycle with the given request; inputs change 1 time unit after
  // the edge so sampling never races the active edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clock);
    #1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       w;
    logic       r;
    tests_run    = 0;
    tests_failed = 0;
    clock   = 1'b0;
    reset   = 1'b1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;

    // Reset held with random requests.
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_dout", 32'(data_out), 32'h0);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    check("post_rst_empty", 32'(empty), 32'd1);
`ifdef ASYNC_FIFO_STATUS_EN
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
`endif

    // Fill with 0x11..0x88.
    for (int k = 0; k < 8; k++) begin
      d = 8'h11 * 8'(k + 1);
      cyc(1'b1, 1'b0, d);
      check("fill_head", 32'(data_out), 32'h11);
      check("fill_empty", 32'(empty), 32'd0);
      check("fill_full", 32'(full), (k == 7) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 1'b0, 8'h99);
    check("drop9_full", 32'(full), 32'd1);
    check("drop9_head", 32'(data_out), 32'h11);
`ifdef ASYNC_FIFO_STATUS_EN
    check("drop9_ovf", 32'(overflow), 32'd1);
    check("drop9_level", 32'(level), 32'd8);
`endif
    for (int k = 0; k < 8; k++) begin
      check("drain_data", 32'(data_out), 32'(8'h11 * 8'(k + 1)));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_full", 32'(full), 32'd0);
    // rptr = 8 indexes slot 0, which still holds 0x11.
    check("stale_dout", 32'(data_out), 32'h11);

    // Read past empty: pointer frozen.
    cyc(1'b0, 1'b1, 8'h00);
    check("underrd_empty", 32'(empty), 32'd1);
    check("underrd_dout", 32'(data_out), 32'h11);
`ifdef ASYNC_FIFO_STATUS_EN
    check("underrd_unf", 32'(underflow), 32'd1);
`endif
    cyc(1'b1, 1'b0, 8'h5A);
    check("sa_5a_dout", 32'(data_out), 32'h5A);
    check("sa_5a_empty", 32'(empty), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    check("sa_5a_pop_empty", 32'(empty), 32'd1);

    // Ordering and wrap-around streaming, occupancy kept in 1..7.
    cyc(1'b1, 1'b0, 8'hA5);
    model_q.push_back(8'hA5);
    cyc(1'b1, 1'b0, 8'h3C);
    model_q.push_back(8'h3C);
    check("stream_head0", 32'(data_out), 32'hA5);
    for (int i = 0; i < 60; i++) begin
      w = (model_q.size() < 7) && ((i % 4) != 3);
      r = (model_q.size() > 1) && ((i % 4) != 0);
      d = 8'((i * 37 + 5) & 8'hFF);
      if (r) check("stream_data", 32'(data_out), 32'(model_q[0]));
      cyc(w, r, d);
      if (r) void'(model_q.pop_front());
      if (w) model_q.push_back(d);
      check("stream_full", 32'(full), 32'd0);
      check("stream_empty", 32'(empty), (model_q.size() == 0) ? 32'd1 : 32'd0);
    end
    while (model_q.size() > 0) begin
      check("stream_tail", 32'(data_out), 32'(model_q[0]));
      cyc(1'b0, 1'b1, 8'h00);
      void'(model_q.pop_front());
    end
    check("stream_end_empty", 32'(empty), 32'd1);

    // Simultaneous read+write while full: pop happens, write dropped.
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 8'hC0 + 8'(k));
    check("sim_full_pre", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 8'hEE);
    check("sim_full_flag", 32'(full), 32'd0);
    check("sim_full_head", 32'(data_out), 32'hC1);
`ifdef ASYNC_FIFO_STATUS_EN
    check("sim_full_level", 32'(level), 32'd7);
    check("sim_full_ovf", 32'(overflow), 32'd1);
`endif
    for (int k = 1; k < 8; k++) begin
      check("sim_full_data", 32'(data_out), 32'hC0 + 32'(k));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("sim_full_end", 32'(empty), 32'd1);

    // Simultaneous read+write with 4 stored: occupancy unchanged.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'hD0 + 8'(k));
    cyc(1'b1, 1'b1, 8'hD4);
    check("sim4_head", 32'(data_out), 32'hD1);
`ifdef ASYNC_FIFO_STATUS_EN
    check("sim4_level", 32'(level), 32'd4);
`endif
    for (int k = 1; k < 5; k++) begin
      check("sim4_data", 32'(data_out), 32'hD0 + 32'(k));
      check("sim4_not_empty", 32'(empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("sim4_end", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation, away from any clock edge.
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 8'h78);
    check("mid_pre_head", 32'(data_out), 32'h77);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dout", 32'(data_out), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    check("mid_rst_after", 32'(empty), 32'd1);
`ifdef ASYNC_FIFO_STATUS_EN
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_unf", 32'(underflow), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
